// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit countdown/count-up timer.
package timer_pkg;

    // Controller operating modes.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Code the display decoder treats as "all segments off".
    localparam logic [7:0] BLANK_CODE = 8'd100;

    // Largest value a two-digit display can show.
    localparam logic [7:0] MAX_COUNT  = 8'd99;

    // Clamp an externally supplied value into the displayable range.
    function automatic logic [7:0] sat_count(input logic [7:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

    // Value at which counting stops: 99 when counting up, 0 when counting down.
    function automatic logic [7:0] terminal_value(input logic up);
        return up ? MAX_COUNT : 8'd0;
    endfunction

endpackage

// File: rtl/countdown99_ctrl_if.sv
// Control/status bundle between the timer controller and its user and display stage.
interface countdown99_ctrl_if;
    logic       start;
    logic       pause;
    logic       load;
    logic [7:0] load_value;
    logic       dir;
    logic       blank;
    logic [7:0] data;
    logic       signal_out;
    logic       running;

    // Side that issues commands and watches the display value.
    modport master (
        output start, pause, load, load_value, dir, blank,
        input  data, signal_out, running
    );

    // The timer controller itself.
    modport slave (
        input  start, pause, load, load_value, dir, blank,
        output data, signal_out, running
    );
endinterface

// File: rtl/countdown99_ctrl_prescaler.sv
// Divides the system clock down to one count step every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // Advance only while enabled so a paused timer resumes mid-period; clear restarts the period.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign tick = enable && (count == LAST);
endmodule

// File: rtl/countdown99_ctrl.sv
// 0..99 timer controller feeding a two-digit 7-segment decoder with a value and a done flag.
module countdown99_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int START_VALUE = 99
) (
    input logic clk,
    input logic reset,
    countdown99_ctrl_if.slave bus
);
    localparam logic [7:0] START_COUNT = 8'(START_VALUE);

    state_t     state;
    logic [7:0] count;
    logic       dir_q;
    logic [7:0] data_q;
    logic       signal_q;
    logic       running_q;

    logic       tick;
    logic       pre_enable;
    logic       pre_clear;
    logic [7:0] restart_count;
    logic [7:0] step_count;

    // The period only advances in RUN on cycles with no command that leaves RUN;
    // a fresh start from IDLE/DONE or a load begins a new full period.
    assign pre_enable    = (state == RUN) && !bus.load && !bus.pause;
    assign pre_clear     = bus.load || (bus.start && (state == IDLE || state == DONE));
    assign restart_count = bus.dir ? 8'd0 : START_COUNT;
    assign step_count    = dir_q ? count + 8'd1 : count - 8'd1;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (pre_enable),
        .clear  (pre_clear),
        .tick   (tick)
    );

    // Mode FSM and count register, plus the registered display outputs that trail them by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= START_COUNT;
            dir_q     <= 1'b0;
            data_q    <= START_COUNT;
            signal_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            data_q    <= bus.blank ? BLANK_CODE : count;
            signal_q  <= (state == DONE);
            running_q <= (state == RUN);

            if (bus.load) begin
                count <= sat_count(bus.load_value);
                state <= IDLE;
            end else if (bus.start && state != RUN) begin
                unique case (state)
                    IDLE: begin
                        dir_q <= bus.dir;
                        state <= (count == terminal_value(bus.dir)) ? DONE : RUN;
                    end
                    DONE: begin
                        dir_q <= bus.dir;
                        count <= restart_count;
                        state <= (restart_count == terminal_value(bus.dir)) ? DONE : RUN;
                    end
                    PAUSED: state <= RUN;
                    default: state <= state;
                endcase
            end else if (bus.pause && state == RUN) begin
                state <= PAUSED;
            end else if (bus.pause && state == PAUSED) begin
                state <= RUN;
            end else if (state == RUN && tick) begin
                if (count == terminal_value(dir_q)) begin
                    state <= DONE;
                end else begin
                    count <= step_count;
                    if (step_count == terminal_value(dir_q)) begin
                        state <= DONE;
                    end
                end
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.signal_out = signal_q;
    assign bus.running    = running_q;
endmodule

// File: tb/tb_countdown99_ctrl.sv
// Self-checking bench for countdown99_ctrl against a cycle-level behavioural timer model.
module tb_countdown99_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int START_VALUE = 99;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic clk;
    logic reset;
    countdown99_ctrl_if bus_if ();

    countdown99_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .START_VALUE (START_VALUE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_count;
    int m_elapsed;
    bit m_up;
    int m_data;
    bit m_done;
    bit m_run;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int limit;
        if (reset) begin
            m_mode = M_IDLE; m_count = START_VALUE; m_elapsed = 0; m_up = 0;
            m_data = START_VALUE; m_done = 0; m_run = 0;
            return;
        end
        m_data = bus_if.blank ? 100 : m_count;
        m_done = (m_mode == M_DONE);
        m_run  = (m_mode == M_RUN);
        if (bus_if.load) begin
            m_count = (bus_if.load_value > 99) ? 99 : int'(bus_if.load_value);
            m_mode = M_IDLE; m_elapsed = 0;
        end else if (bus_if.start && m_mode == M_IDLE) begin
            m_up = bus_if.dir; m_elapsed = 0;
            limit = m_up ? 99 : 0;
            m_mode = (m_count == limit) ? M_DONE : M_RUN;
        end else if (bus_if.start && m_mode == M_DONE) begin
            m_up = bus_if.dir; m_elapsed = 0;
            m_count = m_up ? 0 : START_VALUE;
            limit = m_up ? 99 : 0;
            m_mode = (m_count == limit) ? M_DONE : M_RUN;
        end else if (bus_if.start && m_mode == M_PAUSED) begin
            m_mode = M_RUN;
        end else if (bus_if.pause && (m_mode == M_RUN || m_mode == M_PAUSED)) begin
            m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == TICK_DIV) begin
                m_elapsed = 0;
                limit = m_up ? 99 : 0;
                if (m_count != limit) m_count = m_up ? m_count + 1 : m_count - 1;
                if (m_count == limit) m_mode = M_DONE;
            end
        end
    endtask

    // One clock: edge, reference update, settle, then drop the one-cycle command pulses.
    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        bus_if.start = 1'b0;
        bus_if.pause = 1'b0;
        bus_if.load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_step();
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            total++;
            if (bus_if.data !== 8'd99) begin
                bad++; $display("FAIL reset_data cyc=%0d got=%0d want=99", i, bus_if.data);
            end
            total++;
            if (bus_if.running !== 1'b0 || bus_if.signal_out !== 1'b0) begin
                bad++; $display("FAIL reset_flags cyc=%0d got run=%b sig=%b want 0 0", i, bus_if.running, bus_if.signal_out);
            end
        end
    endtask

    task automatic test_count_down();
        bus_if.load = 1'b1; bus_if.load_value = 8'd5;
        clk_step();
        bus_if.start = 1'b1; bus_if.dir = 1'b0;
        clk_step();
        for (int i = 0; i < 30; i++) begin
            clk_step();
            total++;
            if (bus_if.data !== 8'(m_data) || bus_if.signal_out !== m_done || bus_if.running !== m_run) begin
                bad++; $display("FAIL down_step cyc=%0d got d=%0d s=%b r=%b want d=%0d s=%b r=%b",
                                i, bus_if.data, bus_if.signal_out, bus_if.running, m_data, m_done, m_run);
            end
        end
        total++;
        if (bus_if.data !== 8'd0 || bus_if.signal_out !== 1'b1 || bus_if.running !== 1'b0) begin
            bad++; $display("FAIL down_end got d=%0d s=%b r=%b want d=0 s=1 r=0",
                            bus_if.data, bus_if.signal_out, bus_if.running);
        end
    endtask

    task automatic test_count_up();
        bus_if.load = 1'b1; bus_if.load_value = 8'd97;
        clk_step();
        bus_if.start = 1'b1; bus_if.dir = 1'b1;
        clk_step();
        bus_if.dir = 1'b0;
        for (int i = 0; i < 25; i++) begin
            clk_step();
            total++;
            if (bus_if.data !== 8'(m_data) || bus_if.signal_out !== m_done || bus_if.running !== m_run) begin
                bad++; $display("FAIL up_step cyc=%0d got d=%0d s=%b r=%b want d=%0d s=%b r=%b",
                                i, bus_if.data, bus_if.signal_out, bus_if.running, m_data, m_done, m_run);
            end
        end
        total++;
        if (bus_if.data !== 8'd99 || bus_if.signal_out !== 1'b1) begin
            bad++; $display("FAIL up_end got d=%0d s=%b want d=99 s=1", bus_if.data, bus_if.signal_out);
        end
    endtask

    task automatic test_pause();
        bus_if.load = 1'b1; bus_if.load_value = 8'd20;
        clk_step();
        bus_if.start = 1'b1; bus_if.dir = 1'b0;
        clk_step();
        for (int i = 0; i < 80; i++) begin
            if (i == 5 || i == 46) bus_if.pause = 1'b1;
            clk_step();
            total++;
            if (bus_if.data !== 8'(m_data) || bus_if.running !== m_run) begin
                bad++; $display("FAIL pause_step cyc=%0d got d=%0d r=%b want d=%0d r=%b",
                                i, bus_if.data, bus_if.running, m_data, m_run);
            end
            if (i == 40) begin
                total++;
                if (bus_if.data !== 8'd19 || bus_if.running !== 1'b0) begin
                    bad++; $display("FAIL pause_frozen got d=%0d r=%b want d=19 r=0", bus_if.data, bus_if.running);
                end
            end
        end
    endtask

    task automatic test_load_blank();
        bus_if.load = 1'b1; bus_if.load_value = 8'd200;
        clk_step();
        clk_step();
        total++;
        if (bus_if.data !== 8'd99) begin
            bad++; $display("FAIL load_sat got=%0d want=99", bus_if.data);
        end
        bus_if.start = 1'b1; bus_if.dir = 1'b0;
        clk_step();
        for (int i = 0; i < 40; i++) begin
            bus_if.blank = (i >= 5 && i < 25);
            clk_step();
            total++;
            if (bus_if.data !== 8'(m_data)) begin
                bad++; $display("FAIL blank_step cyc=%0d got=%0d want=%0d", i, bus_if.data, m_data);
            end
            if (i == 10) begin
                total++;
                if (bus_if.data !== 8'd100) begin
                    bad++; $display("FAIL blank_code got=%0d want=100", bus_if.data);
                end
            end
        end
        total++;
        if (bus_if.data !== 8'd90) begin
            bad++; $display("FAIL unblank_count got=%0d want=90", bus_if.data);
        end
        bus_if.blank = 1'b0;
    endtask

    task automatic test_priority();
        logic [7:0] lv;
        bus_if.load = 1'b1; bus_if.load_value = 8'd30;
        clk_step();
        bus_if.start = 1'b1;
        clk_step();
        for (int i = 0; i < 10; i++) clk_step();
        reset = 1'b1; bus_if.start = 1'b1;
        clk_step();
        reset = 1'b0;
        total++;
        if (bus_if.data !== 8'd99 || bus_if.running !== 1'b0) begin
            bad++; $display("FAIL reset_over_start got d=%0d r=%b want d=99 r=0", bus_if.data, bus_if.running);
        end
        clk_step();
        clk_step();
        total++;
        if (bus_if.running !== 1'b0 || bus_if.data !== 8'd99) begin
            bad++; $display("FAIL reset_idle got d=%0d r=%b want d=99 r=0", bus_if.data, bus_if.running);
        end
        lv = 8'($urandom_range(1, 98));
        bus_if.load = 1'b1; bus_if.start = 1'b1; bus_if.load_value = lv;
        clk_step();
        for (int i = 0; i < 8; i++) clk_step();
        total++;
        if (bus_if.data !== lv || bus_if.running !== 1'b0) begin
            bad++; $display("FAIL load_over_start got d=%0d r=%b want d=%0d r=0", bus_if.data, bus_if.running, lv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 99) < 1);
            bus_if.load       = ($urandom_range(0, 99) < 3);
            bus_if.start      = ($urandom_range(0, 99) < 8);
            bus_if.pause      = ($urandom_range(0, 99) < 6);
            bus_if.dir        = 1'($urandom_range(0, 1));
            bus_if.load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) bus_if.blank = ~bus_if.blank;
            clk_step();
            reset = 1'b0;
            total++;
            if (bus_if.data !== 8'(m_data) || bus_if.signal_out !== m_done || bus_if.running !== m_run) begin
                bad++; $display("FAIL random_step cyc=%0d got d=%0d s=%b r=%b want d=%0d s=%b r=%b",
                                i, bus_if.data, bus_if.signal_out, bus_if.running, m_data, m_done, m_run);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_if.start = 1'b0; bus_if.pause = 1'b0; bus_if.load = 1'b0;
        bus_if.load_value = 8'd0; bus_if.dir = 1'b0; bus_if.blank = 1'b0;
        test_reset();
        test_count_down();
        test_count_up();
        test_pause();
        test_load_blank();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
